// File: rtl/inv_addr_seq_pkg.sv
// Shared types and constant helpers for the cofactor/adjugate address sequencer.
package inv_addr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rc_counter.sv
// Row-major row/col counter for an N x N matrix; wrap flags the (N-1,N-1) position.
module rc_counter
  import inv_addr_seq_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned RW = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [RW-1:0] row,
  output logic [RW-1:0] col,
  output logic          wrap
);

  localparam logic [RW-1:0] MAX = RW'(N - 1);

  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] col_q, col_d;
  logic          col_end;

  assign col_end = (col_q == MAX);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = (row_q == MAX) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign wrap = col_end && (row_q == MAX);

endmodule

// File: rtl/inv_addr_seq.sv
// Element address sequencer for matrix inversion: walks all N*N cofactors,
// emitting source index, (optionally transposed) destination index and sign.
module inv_addr_seq
  import inv_addr_seq_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = clog2(N * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  input  logic          transpose,
  output logic          busy,
  output logic          en,
  output logic          sign,
  output logic [AW-1:0] addr_src,
  output logic [AW-1:0] addr_dst,
  output logic          last,
  output logic          done
);

  localparam int unsigned RW = (clog2(N) > 0) ? clog2(N) : 1;

  state_e        state_q, state_d;
  logic          tr_q, tr_d;
  logic          clr;
  logic          run;
  logic          wrap;
  logic [RW-1:0] row, col;
  logic [AW-1:0] idx_rc, idx_cr;

  rc_counter #(.N(N)) u_rc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .inc_i (en),
    .row   (row),
    .col   (col),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tr_q    <= tr_d;
    end
  end

  // Sweep control; transpose mode is captured only when a sweep is accepted.
  always_comb begin
    state_d = state_q;
    tr_d    = tr_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          tr_d    = transpose;
          clr     = 1'b1;
        end
      end
      RUN:     if (!stall && wrap) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign run    = (state_q == RUN);
  assign idx_rc = AW'(row) * AW'(N) + AW'(col);
  assign idx_cr = AW'(col) * AW'(N) + AW'(row);

  // Everything except busy/done is forced to zero outside RUN.
  assign busy     = run;
  assign en       = run && !stall;
  assign sign     = run && (row[0] ^ col[0]);
  assign addr_src = run ? idx_rc : '0;
  assign addr_dst = run ? (tr_q ? idx_cr : idx_rc) : '0;
  assign last     = run && wrap;
  assign done     = (state_q == DONE);

endmodule

// File: doc/inv_addr_seq.md
INV_ADDR_SEQ -- requirements
Module: inv_addr_seq

Interface
REQ-001 The block SHALL have parameter N, default 4, the matrix dimension; legal range 2..8.
REQ-002 The block SHALL have derived parameter AW, default clog2(N*N), the element address width.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit: the reset, synchronous and active-high.
REQ-005 Port start SHALL be input, 1 bit: request one full N*N sweep; sampled only in IDLE.
REQ-006 Port stall SHALL be input, 1 bit: downstream not ready; freezes the sweep.
REQ-007 Port transpose SHALL be input, 1 bit: latched at start; selects adjugate (transposed) write addressing.
REQ-008 Port busy SHALL be output, 1 bit: high in RUN.
REQ-009 Port en SHALL be output, 1 bit: the element beat is valid this cycle (read source, write destination).
REQ-010 Port sign SHALL be output, 1 bit: cofactor sign of the current element; 1 = negate.
REQ-011 Port addr_src SHALL be output, AW bits: the source element index row*N+col.
REQ-012 Port addr_dst SHALL be output, AW bits: the destination element index.
REQ-013 Port last SHALL be output, 1 bit: the current beat is element (N-1,N-1).
REQ-014 Port done SHALL be output, 1 bit: a one-cycle pulse on sweep completion.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE on a non-stalled last beat.
- DONE->IDLE unconditionally after 1 cycle.
REQ-016 On start in IDLE, the block SHALL clear row and col to 0 and latch transpose; the first beat appears the next cycle, giving 1-cycle latency.
REQ-017 en SHALL be high in RUN when stall is 0, and low otherwise.
REQ-018 Each cycle with en high SHALL be one beat; col increments, wraps from N-1 to 0 and then increments row (row-major order).
REQ-019 While stall is high, row, col, sign and the addresses SHALL hold, en SHALL be 0, and no beat is counted.
REQ-020 sign SHALL equal (row XOR col) bit 0, i.e. checkerboard parity; sign SHALL be 0 whenever the block is not in RUN.
REQ-021 addr_dst SHALL be col*N+row when the latched transpose is 1, and row*N+col otherwise.
REQ-022 addr_src, addr_dst, sign and last SHALL be driven to 0 (never Z) outside RUN.
REQ-023 last SHALL be high only when row=N-1, col=N-1 and the block is in RUN, including stalled cycles.
REQ-024 done SHALL be high exactly during the DONE cycle.
REQ-025 A full sweep SHALL produce exactly N*N beats and take N*N plus stall-cycle count cycles in RUN.
REQ-026 start while in RUN or DONE SHALL be ignored, with no restart and no queuing.
REQ-027 start asserted in the DONE cycle SHALL NOT be honoured; start asserted in the IDLE cycle that follows DONE SHALL begin a new sweep.
REQ-028 Address arithmetic SHALL be unsigned AW-bit with no overflow for N<=8, since the largest index is N*N-1 <= 63.

Reset
REQ-029 rst SHALL take priority over all other inputs on the same edge and force state IDLE, row=0, col=0 and latched transpose=0.
REQ-030 After reset, busy, en, sign, last and done SHALL all be 0.
REQ-031 rst asserted mid-sweep SHALL abort the sweep with no done pulse.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the clog2 constant function.
REQ-033 The row/col wrap counter with enable SHALL be one sub-module named rc_counter, parameter N, with outputs row, col and wrap.
REQ-034 All remaining logic SHALL reside in inv_addr_seq; the expected implementation size is 120-400 lines of RTL.

Verification
REQ-035 With N=4, start for 1 cycle and no stall, the bench SHALL check 16 beats in consecutive cycles with addr_src 0..15, sign sequence 0101 1010 0101 1010, last on beat 15, and done on the following cycle.
REQ-036 With N=4 and transpose=1, the bench SHALL check addr_dst sequence 0,4,8,12,1,5,9,13,...,15 while addr_src runs 0..15.
REQ-037 With N=3, the bench SHALL check 9 beats and a sign pattern of 010 101 010.
REQ-038 With N=4 and stall held high for 3 cycles at beat 5, the bench SHALL check that addr_src holds 5 with en=0, the sweep resumes, and done arrives 3 cycles later than in REQ-035.
REQ-039 With N=4, the bench SHALL check that start pulsed at beat 7 is ignored, start during DONE is ignored, and start in the next IDLE cycle begins a new sweep from 0.
REQ-040 With N=4 and rst asserted at beat 9, the bench SHALL check that all outputs are 0 the next cycle, no done pulse occurs, and a subsequent start restarts at addr_src=0.
